// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result FIFOs (ALU, memory), round-robin pick, registered broadcast.
// Define CDB_STATS_EN to add saturating conflict/stall counters (stat_conflict, stat_stall).
module cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_des,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [TAG_W-1:0]  mem_des,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [TAG_W-1:0]  cdb_des,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]       stat_conflict,
  output logic [15:0]       stat_stall
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Source index 0 = ALU, 1 = memory unit; matches the cdb_src encoding.
  logic [TAG_W-1:0]  tag_q  [2][FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [CNT_W-1:0]  cnt    [2];

  logic [TAG_W-1:0]  in_des  [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_valid;
  logic [1:0]        ready;
  logic [1:0]        nonempty;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        grant;
  logic              win_src;
  logic              rr_last;

  assign in_valid   = {mem_valid, alu_valid};
  assign in_des[0]  = alu_des;
  assign in_des[1]  = mem_des;
  assign in_data[0] = alu_data;
  assign in_data[1] = mem_data;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ready[s]    = (cnt[s] < CNT_W'(FIFO_DEPTH));
      nonempty[s] = (cnt[s] != '0);
      push[s]     = in_valid[s] && ready[s] && (in_des[s] != '0) && !flush;
    end
  end

  assign alu_ready = ready[0];
  assign mem_ready = ready[1];

  always_comb begin
    grant   = 2'b00;
    win_src = 1'b0;
    if (&nonempty) begin
      win_src = ~rr_last;
      grant   = rr_last ? 2'b01 : 2'b10;
    end else if (nonempty[0]) begin
      win_src = 1'b0;
      grant   = 2'b01;
    end else if (nonempty[1]) begin
      win_src = 1'b1;
      grant   = 2'b10;
    end
  end

  assign pop = grant & {2{!flush}};

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        tag_q[s][wr_ptr[s]]  <= in_des[s];
        data_q[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      cdb_des  <= '0;
      cdb_data <= '0;
      cdb_src  <= 1'b0;
      rr_last  <= 1'b1;
    end else if (flush) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      cdb_des <= '0;
      rr_last <= 1'b1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        if (push[s] && !pop[s])      cnt[s] <= cnt[s] + CNT_W'(1);
        else if (pop[s] && !push[s]) cnt[s] <= cnt[s] - CNT_W'(1);
      end
      if (|grant) begin
        cdb_des  <= tag_q[win_src][rd_ptr[win_src]];
        cdb_data <= data_q[win_src][rd_ptr[win_src]];
        cdb_src  <= win_src;
      end else begin
        cdb_des <= '0;
      end
      // Round-robin pointer only moves when there was a real contest.
      if (&nonempty) rr_last <= win_src;
    end
  end

`ifdef CDB_STATS_EN
  logic conflict_evt;
  logic stall_evt;

  assign conflict_evt = &nonempty;
  assign stall_evt    = (alu_valid && !ready[0]) || (mem_valid && !ready[1]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_conflict <= '0;
      stat_stall    <= '0;
    end else begin
      if (conflict_evt && (stat_conflict != 16'hFFFF)) stat_conflict <= stat_conflict + 16'd1;
      if (stall_evt && (stat_stall != 16'hFFFF))       stat_stall    <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; checks reset, latency, round-robin order, full/hold, tag-0 drop,
// flush and mid-burst reset. Counter checks are compiled in when CDB_STATS_EN is defined.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alu_valid;
  logic [2:0]  alu_des;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_des;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [2:0]  cdb_des;
  logic [31:0] cdb_data;
  logic        cdb_src;
`ifdef CDB_STATS_EN
  logic [15:0] stat_conflict;
  logic [15:0] stat_stall;
  logic [15:0] c_snap;
  logic [15:0] s_snap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.DATA_W(32), .TAG_W(3), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_des   (alu_des),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_des   (mem_des),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .cdb_des   (cdb_des),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
`ifdef CDB_STATS_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_stall    (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [2:0] des, input logic [31:0] data, input logic src);
    check({tag, ".des"}, 64'(cdb_des), 64'(des));
    check({tag, ".data"}, 64'(cdb_data), 64'(data));
    check({tag, ".src"}, 64'(cdb_src), 64'(src));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_des = '0; alu_data = '0;
    mem_valid = 1'b0; mem_des = '0; mem_data = '0;

    // reset then idle
    tick(); tick();
    bus("reset", 3'd0, 32'h0, 1'b0);
    check("reset.alu_ready", 64'(alu_ready), 64'd1);
    check("reset.mem_ready", 64'(mem_ready), 64'd1);
`ifdef CDB_STATS_EN
    check("reset.stat_conflict", 64'(stat_conflict), 64'd0);
    check("reset.stat_stall", 64'(stat_stall), 64'd0);
`endif
    rst = 1'b1;
    tick();
    check("idle.des", 64'(cdb_des), 64'd0);

    // single ALU push: accepted at E, visible after E+1
    alu_valid = 1'b1; alu_des = 3'd3; alu_data = 32'h0000_1234;
    tick();
    alu_valid = 1'b0;
    check("single.no_bypass", 64'(cdb_des), 64'd0);
    check("single.alu_ready", 64'(alu_ready), 64'd1);
    tick();
    bus("single.bcast", 3'd3, 32'h0000_1234, 1'b0);
    tick();
    bus("single.idle", 3'd0, 32'h0000_1234, 1'b0);

    // simultaneous pushes twice: 1,4,1,4 with no gaps
    alu_valid = 1'b1; alu_des = 3'd1; alu_data = 32'hA000_0001;
    mem_valid = 1'b1; mem_des = 3'd4; mem_data = 32'hB000_0001;
    tick();
    check("rr.e0.des", 64'(cdb_des), 64'd0);
    alu_data = 32'hA000_0002; mem_data = 32'hB000_0002;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    bus("rr.e1", 3'd1, 32'hA000_0001, 1'b0);
    check("rr.e1.mem_ready_full", 64'(mem_ready), 64'd0);
    check("rr.e1.alu_ready", 64'(alu_ready), 64'd1);
    tick();
    bus("rr.e2", 3'd4, 32'hB000_0001, 1'b1);
    tick();
    bus("rr.e3", 3'd1, 32'hA000_0002, 1'b0);
    tick();
    bus("rr.e4", 3'd4, 32'hB000_0002, 1'b1);
    tick();
    check("rr.e5.idle", 64'(cdb_des), 64'd0);

    // ALU FIFO fills while memory competes; tag 3 held until ready
`ifdef CDB_STATS_EN
    c_snap = stat_conflict; s_snap = stat_stall;
`endif
    alu_valid = 1'b1; alu_des = 3'd1; alu_data = 32'hD000_0001;
    mem_valid = 1'b1; mem_des = 3'd5; mem_data = 32'hC000_0005;
    tick();
    alu_des = 3'd2; alu_data = 32'hD000_0002;
    mem_des = 3'd6; mem_data = 32'hC000_0006;
    tick();
    bus("full.e1", 3'd5, 32'hC000_0005, 1'b1);
    check("full.e1.alu_ready", 64'(alu_ready), 64'd0);
    mem_valid = 1'b0;
    alu_des = 3'd3; alu_data = 32'hD000_0003;
    tick();
    bus("full.e2", 3'd1, 32'hD000_0001, 1'b0);
    check("full.e2.alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    bus("full.e3", 3'd6, 32'hC000_0006, 1'b1);
    check("full.e3.alu_ready", 64'(alu_ready), 64'd0);
    tick();
    bus("full.e4", 3'd2, 32'hD000_0002, 1'b0);
    tick();
    bus("full.e5", 3'd3, 32'hD000_0003, 1'b0);
    tick();
    bus("full.e6", 3'd0, 32'hD000_0003, 1'b0);
`ifdef CDB_STATS_EN
    check("full.conflicts", 64'(stat_conflict - c_snap), 64'd3);
    check("full.stalls", 64'(stat_stall - s_snap), 64'd1);
`endif

    // tag-0 result is dropped
    alu_valid = 1'b1; alu_des = 3'd0; alu_data = 32'h5555_5555;
    tick();
    alu_valid = 1'b0;
    check("tag0.des", 64'(cdb_des), 64'd0);
    check("tag0.alu_ready", 64'(alu_ready), 64'd1);
    tick();
    bus("tag0.after", 3'd0, 32'hD000_0003, 1'b0);

    // flush with both FIFOs holding entries
`ifdef CDB_STATS_EN
    c_snap = stat_conflict;
`endif
    alu_valid = 1'b1; alu_des = 3'd2; alu_data = 32'hE000_0002;
    mem_valid = 1'b1; mem_des = 3'd7; mem_data = 32'hE000_0007;
    tick();
    alu_des = 3'd3; alu_data = 32'hE000_0003;
    mem_des = 3'd5; mem_data = 32'hE000_0005;
    tick();
    bus("flush.pre", 3'd2, 32'hE000_0002, 1'b0);
    flush = 1'b1;
    alu_des = 3'd4; mem_des = 3'd6;
    tick();
    flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    check("flush.des", 64'(cdb_des), 64'd0);
    check("flush.alu_ready", 64'(alu_ready), 64'd1);
    check("flush.mem_ready", 64'(mem_ready), 64'd1);
`ifdef CDB_STATS_EN
    check("flush.stats_kept", 64'(stat_conflict - c_snap), 64'd2);
`endif
    tick();
    check("flush.no_stale1", 64'(cdb_des), 64'd0);
    tick();
    check("flush.no_stale2", 64'(cdb_des), 64'd0);

    // rr_last back to 1 after flush: ALU wins the next tie
    alu_valid = 1'b1; alu_des = 3'd1; alu_data = 32'hF000_0001;
    mem_valid = 1'b1; mem_des = 3'd2; mem_data = 32'hF000_0002;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("postflush.e0", 64'(cdb_des), 64'd0);
    tick();
    bus("postflush.e1", 3'd1, 32'hF000_0001, 1'b0);
    tick();
    bus("postflush.e2", 3'd2, 32'hF000_0002, 1'b1);
    tick();
    check("postflush.idle", 64'(cdb_des), 64'd0);

    // reset mid-burst discards buffered results
    alu_valid = 1'b1; alu_des = 3'd5; alu_data = 32'h1111_0005;
    mem_valid = 1'b1; mem_des = 3'd6; mem_data = 32'h1111_0006;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    rst = 1'b0;
    tick();
    bus("midrst", 3'd0, 32'h0, 1'b0);
    check("midrst.alu_ready", 64'(alu_ready), 64'd1);
    check("midrst.mem_ready", 64'(mem_ready), 64'd1);
`ifdef CDB_STATS_EN
    check("midrst.stat_conflict", 64'(stat_conflict), 64'd0);
`endif
    rst = 1'b1;
    tick();
    check("midrst.after1", 64'(cdb_des), 64'd0);
    tick();
    check("midrst.after2", 64'(cdb_des), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
